fadd_arbiter: RTL and testbench
===============================

Name: fadd_arbiter

Overview:
- Shares one combinational `fadd` instance (`x1`, `x2` -> `y`, `ovf`) between N requesters.
- Each requester has an operand valid/ready handshake. The round-robin grant captures the operands, runs the adder for one cycle and registers the result.
- The result is returned on a single valid/ready output carrying the requester ID.
- Sits between the FP issue logic and the shared single-precision adder.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must be >= clog2(N).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N  bit i set: requester i presents operands.
- req_ready  output  N  bit i set: operands of requester i accepted this cycle (one-hot or zero).
- req_x1  input  32*N  operand A of requester i, in bits [32i+31:32i].
- req_x2  input  32*N  operand B of requester i, same packing.
- res_valid  output  1  result is held and valid.
- res_ready  input  1  consumer accepts the result.
- res_y  output  32  IEEE-754 single sum from `fadd`.
- res_ovf  output  1  overflow flag from `fadd`.
- res_id  output  IDW  index of the requester that owns the result.

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- Reset (rst=1 at posedge), wins over every other event:
  - state=IDLE, ptr=0;
  - res_valid=0, res_y=0, res_ovf=0, res_id=0;
  - req_ready=0;
  - operand registers cleared.
  - An operation in flight is dropped and no result is produced.
- IDLE:
  - req_ready is combinational and is only nonzero in IDLE.
  - Grant = first i with req_valid[i]=1, scanning ptr, ptr+1, ... wrapping mod N.
  - req_ready[grant]=1 in the same cycle.
  - At posedge: capture req_x1/req_x2 of grant into op_a/op_b, capture grant into id_r, set ptr=(grant+1) mod N, go to EXEC.
  - No req_valid set: stay in IDLE; ptr unchanged.
- EXEC:
  - `fadd` is driven from op_a/op_b.
  - At posedge: res_y<=y, res_ovf<=ovf, res_id<=id_r, res_valid<=1, go to DONE.
- DONE:
  - Outputs held stable while res_valid=1 and res_ready=0.
  - At posedge with res_ready=1: res_valid<=0, go to IDLE. res_y/res_ovf/res_id keep their last values.
- Latency: operand handshake at cycle t -> res_valid=1 at cycle t+2.
  - Minimum issue interval is 3 cycles with res_ready held high.
- Handshake rules:
  - A requester may not change its operands while req_valid=1 and req_ready=0.
  - Dropping req_valid before grant is legal; that request is lost with no effect.
- Simultaneous requests: exactly one is granted per IDLE cycle. All N asserted continuously -> grants rotate ptr order, giving fairness within N operations.
- ptr wrap: grant of N-1 sets ptr=0.
- res_ready asserted while res_valid=0: ignored.
- Arithmetic: no rounding or special-case handling in this block. res_y and res_ovf are exactly `fadd`'s outputs for the captured operands. A result with ovf=1 is still delivered.
- Assertions for the verification engineer:
  - req_ready is one-hot or zero;
  - req_ready=0 unless state=IDLE;
  - res_* stable while res_valid && !res_ready.

Test Plan:
- Single request: requester 0 sends x1=0x3F800000, x2=0x40000000 (1.0+2.0).
  - req_ready[0] is 1 in the issue cycle.
  - 2 cycles later: res_valid=1, res_y=0x40400000, res_ovf=0, res_id=0.
- Exponent-130 case: requester 2 sends x1=x2=0x4100000A.
  - Required: res_y=0x4180000A, res_id=2, and it matches $shortrealtobits of the shortreal sum.
- Round-robin: all 4 req_valid held high, res_ready=1, same operands throughout.
  - Grants occur in order 0,1,2,3,0.
  - res_id follows the same sequence, with grants spaced 3 cycles apart.
- Backpressure: res_ready=0 for 5 cycles after res_valid rises.
  - res_y/res_id/res_ovf stay stable and req_ready stays 0.
  - res_ready=1 -> res_valid drops the next cycle, and the next grant occurs in the following IDLE cycle.
- Overflow: x1=x2=0x7F7FFFFF.
  - res_ovf=1, res_valid=1, and res_y equals `fadd`'s output for these operands.
- Reset mid-operation: assert rst in EXEC.
  - Next cycle: state IDLE, res_valid=0, ptr=0, and no result is produced for the dropped request.
  - Re-request from requester 3 -> res_id=3.

Source files
------------

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter that time-shares one combinational single-precision adder
// between N requesters; one operation in flight, result held until consumed.

module fadd (
    input  logic [31:0] x1_i,
    input  logic [31:0] x2_i,
    output logic [31:0] y_o,
    output logic        ovf_o
);
    logic        a_big, sign, zero;
    logic [31:0] big, sml;
    logic [7:0]  e_big, e_sml, shamt;
    logic [23:0] m_big, m_sml, m_al, dif;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic [8:0]  exp_r;
    logic [22:0] frac;

    // Truncating adder: align the smaller magnitude, add or subtract, renormalise.
    always_comb begin
        a_big = (x1_i[30:0] >= x2_i[30:0]);
        big   = a_big ? x1_i : x2_i;
        sml   = a_big ? x2_i : x1_i;
        e_big = big[30:23];
        e_sml = sml[30:23];
        m_big = {|e_big, big[22:0]};
        m_sml = {|e_sml, sml[22:0]};
        shamt = e_big - e_sml;
        m_al  = (shamt > 8'd23) ? 24'd0 : (m_sml >> shamt);
        sum   = {1'b0, m_big} + {1'b0, m_al};
        dif   = m_big - m_al;
        lz    = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (dif[i]) lz = 5'(23 - i);
        end
        sign  = big[31];
        exp_r = {1'b0, e_big};
        frac  = 23'd0;
        zero  = 1'b0;
        if (big[31] == sml[31]) begin
            if (sum[24]) begin
                exp_r = exp_r + 9'd1;
                frac  = sum[23:1];
            end else begin
                frac = sum[22:0];
                if (e_big == 8'd0 && sum[23]) exp_r = 9'd1;
            end
        end else if (dif == 24'd0 || {4'd0, lz} >= exp_r) begin
            zero = 1'b1;
        end else begin
            frac  = 23'(dif << lz);
            exp_r = exp_r - {4'd0, lz};
        end
        ovf_o = (exp_r >= 9'd255);
        if (zero)       y_o = 32'd0;
        else if (ovf_o) y_o = {sign, 8'hFF, 23'd0};
        else            y_o = {sign, exp_r[7:0], frac};
    end
endmodule

module fadd_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [32*N-1:0] req_x1,
    input  logic [32*N-1:0] req_x2,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_y,
    output logic            res_ovf,
    output logic [IDW-1:0]  res_id,
    output logic [1:0]      dbg_state_o,
    output logic [IDW-1:0]  dbg_ptr_o
);
    // Valid/ready: a transfer happens on a posedge where valid and ready are both 1;
    // a requester holds its operands stable until then, the result is held until then.
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, grant, res_id_q;
    logic [31:0]    op_a_q, op_b_q, res_y_q, y;
    logic           res_valid_q, res_ovf_q, found, ovf;
    int             idx;

    fadd u_fadd (.x1_i(op_a_q), .x2_i(op_b_q), .y_o(y), .ovf_o(ovf));

    // First valid requester scanning from ptr, wrapping modulo N.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
        ptr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
        req_ready = '0;
        if (state_q == IDLE && found) req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    op_a_q  <= req_x1[32*int'(grant) +: 32];
                    op_b_q  <= req_x2[32*int'(grant) +: 32];
                    id_q    <= grant;
                    ptr_q   <= ptr_d;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_y_q     <= y;
                    res_ovf_q   <= ovf;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid   = res_valid_q;
    assign res_y       = res_y_q;
    assign res_ovf     = res_ovf_q;
    assign res_id      = res_id_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter: expected results queued at issue time,
// popped and compared by a monitor whenever a result is consumed.

module tb_fadd_arbiter;
    localparam int N = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready;
    logic [32*N-1:0] req_x1, req_x2;
    logic            res_valid, res_ready, res_ovf;
    logic [31:0]     res_y;
    logic [IDW-1:0]  res_id, dbg_ptr;
    logic [1:0]      dbg_state;

    int tests = 0;
    int errors = 0;
    int cyc = 0;

    logic [34:0] exp_q[$];
    int          gcyc_q[$];
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [34:0] held = '0;

    fadd_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_ovf(res_ovf), .res_id(res_id),
        .dbg_state_o(dbg_state), .dbg_ptr_o(dbg_ptr)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        errors++;
        $display("FAIL %s: timeout or missing event (cycle %0d)", name, cyc);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            if (dbg_state != 2'd0) check("req_ready_idle_only", 64'(req_ready), 64'd0);
            if (|req_ready) gcyc_q.push_back(cyc);
            if (res_valid && !prev_valid) begin
                if (gcyc_q.size() == 0) fail_now("latency_no_grant");
                else check("latency", 64'(cyc - gcyc_q.pop_front()), 64'd2);
            end
            if (res_valid && prev_valid && !prev_ready) begin
                check("stall_stable", 64'({res_id, res_ovf, res_y}), 64'(held));
                check("stall_no_ready", 64'(req_ready), 64'd0);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_result");
                else check("result", 64'({res_id, res_ovf, res_y}), 64'(exp_q.pop_front()));
            end
        end
        prev_valid = res_valid;
        prev_ready = res_ready;
        held = {res_id, res_ovf, res_y};
    end

    // driver tasks
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, output int waited);
        bit got = 0;
        waited = 0;
        req_valid[id] = 1'b1;
        req_x1[id*32 +: 32] = a;
        req_x2[id*32 +: 32] = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin got = 1; break; end
            waited++;
        end
        if (!got) fail_now("issue_grant");
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin done = 1; break; end
        end
        if (!done) fail_now("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
        $fatal(1);
    end

    initial begin
        int w, grants;
        int rr_cyc[5];
        bit got;
        rst = 1'b1;
        req_valid = '0;
        req_x1 = '0;
        req_x2 = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_ptr", 64'(dbg_ptr), 64'd0);
        check("rst_res", 64'({res_valid, res_id, res_ovf, res_y}), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;

        // single request, 1.0 + 2.0
        exp_q.push_back({2'd0, 1'b0, 32'h40400000});
        issue(0, 32'h3F800000, 32'h40000000, w);
        check("single_immediate_grant", 64'(w), 64'd0);
        drain();

        // exponent-130 operands doubled
        exp_q.push_back({2'd2, 1'b0, 32'h4180000A});
        issue(2, 32'h4100000A, 32'h4100000A, w);
        drain();

        // round robin from a fresh pointer
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back({2'(i % 4), 1'b0, 32'h40400000});
        for (int i = 0; i < N; i++) begin
            req_x1[i*32 +: 32] = 32'h3F800000;
            req_x2[i*32 +: 32] = 32'h40000000;
        end
        req_valid = '1;
        grants = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                check("rr_grant_order", 64'(req_ready), 64'(4'b0001 << (grants % 4)));
                rr_cyc[grants] = cyc;
                grants++;
                if (grants == 5) break;
            end
        end
        if (grants != 5) fail_now("rr_grants");
        @(posedge clk); #1 req_valid = '0;
        for (int i = 1; i < grants; i++) check("rr_spacing", 64'(rr_cyc[i] - rr_cyc[i-1]), 64'd3);
        drain();

        // backpressure: 5.0 + 3.0 from req 1 while req 2 (-2.0 + 1.0) waits
        res_ready = 1'b0;
        exp_q.push_back({2'd1, 1'b0, 32'h41000000});
        exp_q.push_back({2'd2, 1'b0, 32'hBF800000});
        req_x1[32 +: 32] = 32'h40A00000;
        req_x2[32 +: 32] = 32'h40400000;
        req_x1[64 +: 32] = 32'hC0000000;
        req_x2[64 +: 32] = 32'h3F800000;
        req_valid = 4'b0110;
        @(negedge clk);
        check("bp_first_grant", 64'(req_ready), 64'h2);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) begin got = 1; break; end
        end
        if (!got) fail_now("bp_res_valid");
        repeat (5) @(negedge clk);
        check("bp_held_valid", 64'(res_valid), 64'd1);
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_dropped", 64'(res_valid), 64'd0);
        check("bp_next_grant", 64'(req_ready), 64'h4);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        drain();

        // overflow: max finite + max finite
        exp_q.push_back({2'd0, 1'b1, 32'h7F800000});
        issue(0, 32'h7F7FFFFF, 32'h7F7FFFFF, w);
        drain();

        // reset while an operation is in EXEC
        issue(1, 32'h3F800000, 32'h40000000, w);
        check("rst_mid_in_exec", 64'(dbg_state), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        check("rst_mid_valid", 64'(res_valid), 64'd0);
        check("rst_mid_ptr", 64'(dbg_ptr), 64'd0);
        gcyc_q.delete();
        repeat (4) @(negedge clk);
        check("rst_mid_no_result", 64'(res_valid), 64'd0);
        @(posedge clk); #1;
        exp_q.push_back({2'd3, 1'b0, 32'h40400000});
        issue(3, 32'h3F800000, 32'h40000000, w);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
